// File: rtl/dff_resp_checker_if.sv
// Stimulus/response bundle between a DFF test driver and dff_resp_checker.
// The driver side owns stimulus and the DUT sample; the checker side owns the verdict.
interface dff_resp_checker_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic             start;
    logic             stim_valid;
    logic [WIDTH-1:0] stim;
    logic [WIDTH-1:0] dut_q;
    logic             end_req;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] chk_count;
    logic [CNT_W-1:0] first_err_idx;

    modport master (
        output start, stim_valid, stim, dut_q, end_req,
        input  busy, done, pass, fail, err_count, chk_count, first_err_idx
    );

    modport slave (
        input  start, stim_valid, stim, dut_q, end_req,
        output busy, done, pass, fail, err_count, chk_count, first_err_idx
    );
endinterface

// File: rtl/dff_resp_checker.sv
// Replays captured stimulus LATENCY cycles later as the expected DUT output, compares it
// against dut_q and keeps saturating check/error counts with a sticky pass/fail verdict.
module dff_resp_checker #(
    parameter int WIDTH       = 1,
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    dff_resp_checker_if.slave bus
);

    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $error("dff_resp_checker: LATENCY must be in 1..16");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        CHECK = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LATENCY-1:0] pipe_v;
    logic [WIDTH-1:0]   pipe_d [LATENCY];
    logic [CNT_W-1:0]   chk_q;
    logic [ERR_W-1:0]   err_q;
    logic [CNT_W-1:0]   first_err_q;
    logic               pass_q;
    logic               fail_q;

    logic               head_v;
    logic [WIDTH-1:0]   head_d;
    logic               run_start;
    logic               load_en;
    logic               load_v;
    logic [WIDTH-1:0]   load_d;
    logic               cmp_en;
    logic               mismatch;
    logic               drained;
    logic               halt_now;
    logic               busy;
    logic               done;

    assign head_v    = pipe_v[LATENCY-1];
    assign head_d    = pipe_d[LATENCY-1];
    assign run_start = bus.start && (state == IDLE || state == HALT);
    assign load_en   = (state == FILL) || (state == CHECK) || (state == DRAIN);
    assign load_v    = (state == DRAIN) ? 1'b0 : bus.stim_valid;
    assign load_d    = (state == DRAIN) ? '0 : bus.stim;
    assign cmp_en    = head_v && load_en;
    // Case inequality so an X/Z on dut_q is scored as a mismatch in simulation.
    assign mismatch  = cmp_en && (bus.dut_q !== head_d);
    assign drained   = (pipe_v == '0);
    assign halt_now  = (STOP_ON_ERR != 0) && mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: begin
                if (bus.start) state_nxt = FILL;
            end
            FILL: begin
                if (halt_now)         state_nxt = HALT;
                else if (bus.end_req) state_nxt = DRAIN;
                else if (head_v)      state_nxt = CHECK;
            end
            CHECK: begin
                if (halt_now)         state_nxt = HALT;
                else if (bus.end_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (halt_now)         state_nxt = HALT;
                else if (drained)     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            FILL, CHECK: busy = 1'b1;
            DRAIN: begin
                busy = 1'b1;
                done = drained;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Expected-value pipeline; DRAIN pushes bubbles so the valids empty out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_d[i] <= '0;
        end else if (run_start) begin
            pipe_v <= '0;
        end else if (load_en) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            pipe_v[0] <= load_v;
            pipe_d[0] <= load_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_q       <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else if (run_start) begin
            chk_q       <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            if (cmp_en && chk_q != '1) chk_q <= chk_q + 1'b1;
            if (mismatch) begin
                if (err_q != '1) err_q <= err_q + 1'b1;
                fail_q <= 1'b1;
                // fail_q is still low only on the first mismatch of the run.
                if (!fail_q) first_err_q <= chk_q;
            end
            if (done) pass_q <= (err_q == '0) && (chk_q != '0);
        end
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass_q;
    assign bus.fail          = fail_q;
    assign bus.err_count     = err_q;
    assign bus.chk_count     = chk_q;
    assign bus.first_err_idx = first_err_q;

endmodule

// File: tb/tb_dff_resp_checker.sv
// Scoreboard bench: three checker instances (latency 1 with 2-bit error count, latency 3,
// stop-on-error) share one stimulus stream and are started one at a time.
module tb_dff_resp_checker;
    localparam int W = 4;

    typedef struct {
        int chk;
        int err;
        int fidx;
        int pass;
        int fail;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] stim;
    logic         stim_valid;
    logic         end_req;
    logic         flip;
    logic         start_a;
    logic         start_b;
    logic         start_c;

    int n_checks = 0;
    int n_errors = 0;

    exp_t qa_exp[$];
    exp_t qb_exp[$];
    exp_t qc_exp[$];
    exp_t cur_a;
    exp_t cur_b;
    exp_t cur_c;
    bit   pend_a = 1'b0;
    bit   pend_b = 1'b0;
    bit   pend_c = 1'b0;

    always #5 clk = ~clk;

    dff_resp_checker_if #(.WIDTH(W), .CNT_W(16), .ERR_W(2)) ia ();
    dff_resp_checker_if #(.WIDTH(W), .CNT_W(16), .ERR_W(8)) ib ();
    dff_resp_checker_if #(.WIDTH(W), .CNT_W(16), .ERR_W(8)) ic ();

    // DUT models: a 1-flop and a 3-flop pipeline; flip corrupts the sample on its way in.
    logic [W-1:0] src;
    logic [W-1:0] q1;
    logic [W-1:0] q3_0, q3_1, q3_2;
    assign src = stim ^ {W{flip}};
    always @(posedge clk) begin
        q1   <= src;
        q3_0 <= src;
        q3_1 <= q3_0;
        q3_2 <= q3_1;
    end

    assign ia.start = start_a;  assign ib.start = start_b;  assign ic.start = start_c;
    assign ia.stim = stim;      assign ib.stim = stim;      assign ic.stim = stim;
    assign ia.stim_valid = stim_valid;
    assign ib.stim_valid = stim_valid;
    assign ic.stim_valid = stim_valid;
    assign ia.end_req = end_req; assign ib.end_req = end_req; assign ic.end_req = end_req;
    assign ia.dut_q = q1;       assign ib.dut_q = q3_2;     assign ic.dut_q = q1;

    dff_resp_checker #(.WIDTH(W), .LATENCY(1), .CNT_W(16), .ERR_W(2), .STOP_ON_ERR(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    dff_resp_checker #(.WIDTH(W), .LATENCY(3), .CNT_W(16), .ERR_W(8), .STOP_ON_ERR(0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    dff_resp_checker #(.WIDTH(W), .LATENCY(1), .CNT_W(16), .ERR_W(8), .STOP_ON_ERR(1))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int chk, input int err, input int fidx,
                                input int pass, input int fail);
        exp_t e;
        e.chk = chk; e.err = err; e.fidx = fidx; e.pass = pass; e.fail = fail;
        return e;
    endfunction

    task automatic cmp_res(input string tag, input exp_t e, input int chk_v, input int err_v,
                           input int fidx_v, input int pass_v, input int fail_v,
                           input int busy_v, input int done_v);
        check({tag, "_chk_count"}, chk_v, e.chk);
        check({tag, "_err_count"}, err_v, e.err);
        check({tag, "_first_err_idx"}, fidx_v, e.fidx);
        check({tag, "_pass"}, pass_v, e.pass);
        check({tag, "_fail"}, fail_v, e.fail);
        check({tag, "_busy_after_done"}, busy_v, 0);
        check({tag, "_done_one_cycle"}, done_v, 0);
    endtask

    // Monitors: a done pulse pops an expectation; results are compared one cycle later,
    // once the sticky pass flag has been registered.
    always @(negedge clk) begin
        if (pend_a) begin
            pend_a = 1'b0;
            cmp_res("a", cur_a, ia.chk_count, ia.err_count, ia.first_err_idx,
                    ia.pass, ia.fail, ia.busy, ia.done);
        end else if (ia.done) begin
            if (qa_exp.size() == 0) check("a_unexpected_done", 1, 0);
            else begin cur_a = qa_exp.pop_front(); pend_a = 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (pend_b) begin
            pend_b = 1'b0;
            cmp_res("b", cur_b, ib.chk_count, ib.err_count, ib.first_err_idx,
                    ib.pass, ib.fail, ib.busy, ib.done);
        end else if (ib.done) begin
            if (qb_exp.size() == 0) check("b_unexpected_done", 1, 0);
            else begin cur_b = qb_exp.pop_front(); pend_b = 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (pend_c) begin
            pend_c = 1'b0;
            cmp_res("c", cur_c, ic.chk_count, ic.err_count, ic.first_err_idx,
                    ic.pass, ic.fail, ic.busy, ic.done);
        end else if (ic.done) begin
            if (qc_exp.size() == 0) check("c_unexpected_done", 1, 0);
            else begin cur_c = qc_exp.pop_front(); pend_c = 1'b1; end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int which);
        start_a = (which == 0);
        start_b = (which == 1);
        start_c = (which == 2);
        cyc();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    // flip_idx: sample to corrupt, -1 none, -2 all. bubble3: every 3rd cycle is a bubble
    // carrying a corrupted value that must never be compared.
    task automatic feed(input int n, input int flip_idx, input bit bubble3, input bit with_end);
        for (int i = 0; i < n; i++) begin
            stim_valid = !(bubble3 && (i % 3 == 2));
            stim       = (i % 2 == 1) ? 4'hA : 4'h5;
            flip       = (flip_idx == -2) || (i == flip_idx) || !stim_valid;
            end_req    = with_end && (i == n - 1);
            cyc();
        end
        stim_valid = 1'b0;
        flip       = 1'b0;
        end_req    = 1'b0;
        stim       = '0;
    endtask

    function automatic int outstanding(input int which);
        case (which)
            0:       return qa_exp.size() + int'(pend_a);
            1:       return qb_exp.size() + int'(pend_b);
            default: return qc_exp.size() + int'(pend_c);
        endcase
    endfunction

    task automatic wait_done(input int which, input string name);
        for (int k = 0; k < 50; k++) begin
            if (outstanding(which) == 0) break;
            cyc();
        end
        check(name, outstanding(which), 0);
    endtask

    initial begin
        rst_n = 1'b0; stim = '0; stim_valid = 1'b0; end_req = 1'b0; flip = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cyc(); cyc();
        check("rst_busy", ia.busy, 0);
        check("rst_done", ia.done, 0);
        check("rst_pass", ia.pass, 0);
        check("rst_fail", ia.fail, 0);
        check("rst_err_count", ia.err_count, 0);
        check("rst_chk_count", ia.chk_count, 0);
        check("rst_first_err_idx", ia.first_err_idx, 0);
        check("rst_busy_b", ib.busy, 0);
        check("rst_busy_c", ic.busy, 0);
        rst_n = 1'b1;
        cyc();

        // Ideal DFF, 20 alternating samples.
        kick(0);
        check("t1_busy_after_start", ia.busy, 1);
        qa_exp.push_back(mk(20, 0, 0, 1, 0));
        feed(20, -1, 1'b0, 1'b1);
        wait_done(0, "t1_done_timeout");

        // 5th sample corrupted.
        kick(0);
        check("t2_pass_cleared", ia.pass, 0);
        qa_exp.push_back(mk(20, 1, 4, 0, 1));
        feed(20, 4, 1'b0, 1'b1);
        wait_done(0, "t2_done_timeout");

        // Always wrong with a 2-bit error counter: saturates at 3.
        kick(0);
        qa_exp.push_back(mk(10, 3, 0, 0, 1));
        feed(10, -2, 1'b0, 1'b1);
        wait_done(0, "t5_done_timeout");

        // Latency 3 with bubbles on every 3rd cycle.
        kick(1);
        qb_exp.push_back(mk(20, 0, 0, 1, 0));
        feed(30, -1, 1'b1, 1'b1);
        wait_done(1, "t3_done_timeout");

        // Stop on error at the 2nd sample; a late end_req is ignored in HALT.
        kick(2);
        feed(6, 1, 1'b0, 1'b1);
        cyc(); cyc(); cyc();
        check("t4_halt_busy", ic.busy, 0);
        check("t4_halt_chk_count", ic.chk_count, 2);
        check("t4_halt_err_count", ic.err_count, 1);
        check("t4_halt_first_err_idx", ic.first_err_idx, 1);
        check("t4_halt_fail", ic.fail, 1);
        check("t4_halt_pass", ic.pass, 0);
        kick(2);
        check("t4_restart_busy", ic.busy, 1);
        check("t4_restart_chk_count", ic.chk_count, 0);
        check("t4_restart_err_count", ic.err_count, 0);
        check("t4_restart_fail", ic.fail, 0);
        check("t4_restart_first_err_idx", ic.first_err_idx, 0);
        qc_exp.push_back(mk(4, 0, 0, 1, 0));
        feed(4, -1, 1'b0, 1'b1);
        wait_done(2, "t4_done_timeout");

        // Start while busy is ignored; reset mid-CHECK aborts without done.
        kick(0);
        feed(5, -1, 1'b0, 1'b0);
        start_a = 1'b1; stim_valid = 1'b1; stim = 4'h5;
        cyc();
        start_a = 1'b0; stim_valid = 1'b0;
        check("t6_start_ignored_busy", ia.busy, 1);
        check("t6_start_ignored_chk", ia.chk_count, 5);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("t6_rst_busy", ia.busy, 0);
        check("t6_rst_done", ia.done, 0);
        check("t6_rst_chk_count", ia.chk_count, 0);
        check("t6_rst_err_count", ia.err_count, 0);
        check("t6_rst_fail", ia.fail, 0);
        check("t6_rst_pass_b", ib.pass, 0);
        check("t6_rst_chk_count_b", ib.chk_count, 0);
        for (int k = 0; k < 6; k++) cyc();
        check("t6_idle_busy", ia.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
